stride_counter: RTL and testbench

- Parametrised successor to the team's fixed odd-number counter.
- Counts from a programmable base in runtime-selectable stride, direction and limit, with three end-of-range modes: wrap, saturate, one-shot.
- Registered terminal-count pulse and done flag.
- Used as an address/sequence generator feeding datapath blocks that need odd, even or strided sequences.

---
 rtl/stride_counter_pkg.sv | 24 ++
 rtl/stride_next.sv | 48 ++++
 rtl/stride_counter.sv | 127 ++++++++++++
 tb/tb_stride_counter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stride_counter_pkg.sv
// Shared types for the stride counter: end-of-range modes, control states and
// the guard-bit helper used by every boundary compare.
package stride_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } cnt_mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } cnt_state_e;

  localparam int unsigned CMP_GUARD_BITS = 1;

  // One guard bit keeps count+step and START+step from wrapping before the compare.
  function automatic int unsigned cmp_width(input int unsigned w);
    return w + CMP_GUARD_BITS;
  endfunction

endpackage

// File: rtl/stride_next.sv
// Combinational next-value and boundary detector for the stride counter.
// A zero stride never reports a boundary and leaves the value unchanged.
module stride_next
  import stride_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  start,
  output logic [WIDTH-1:0]  nxt,
  output logic              hit
);

  localparam int CW = cmp_width(WIDTH);

  logic [CW-1:0] cnt_x;
  logic [CW-1:0] step_x;
  logic [CW-1:0] lim_x;
  logic [CW-1:0] sum_x;
  logic [CW-1:0] floor_x;

  assign cnt_x   = CW'(count);
  assign step_x  = CW'(step);
  assign lim_x   = CW'(limit);
  assign sum_x   = cnt_x + step_x;
  assign floor_x = CW'(start) + step_x;

  always_comb begin
    nxt = count;
    hit = 1'b0;
    if (step != '0) begin
      // An inverted range (limit below start) has no legal landing point.
      if (limit < start)
        hit = 1'b1;
      else if (!dir)
        hit = (sum_x > lim_x);
      else
        hit = (cnt_x < floor_x);
      if (!hit)
        nxt = dir ? (count - WIDTH'(step)) : (count + WIDTH'(step));
    end
  end

endmodule

// File: rtl/stride_counter.sv
// Programmable-stride up/down counter with wrap, saturate and one-shot end modes.
// Optional macro STRIDE_COUNTER_PARITY_LOCK_EN pins count parity to START parity.
module stride_counter
  import stride_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int START  = 1,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              done
`ifdef STRIDE_COUNTER_PARITY_LOCK_EN
  ,
  output logic              parity_err
`endif
);

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);

  function automatic logic [WIDTH-1:0] lock_load(input logic [WIDTH-1:0] v);
`ifdef STRIDE_COUNTER_PARITY_LOCK_EN
    return {v[WIDTH-1:1], START_V[0]};
`else
    return v;
`endif
  endfunction

  function automatic logic [STEP_W-1:0] lock_step(input logic [STEP_W-1:0] s);
`ifdef STRIDE_COUNTER_PARITY_LOCK_EN
    return {s[STEP_W-1:1], 1'b0};
`else
    return s;
`endif
  endfunction

  cnt_mode_e         mode_e;
  cnt_state_e        state_p0;
  logic              sat_hold_p0;
  logic              sat_dir_p0;
  logic [STEP_W-1:0] step_eff;
  logic [WIDTH-1:0]  load_eff;
  logic [WIDTH-1:0]  nxt;
  logic              hit;

  assign mode_e   = cnt_mode_e'(mode);
  assign step_eff = lock_step(step);
  assign load_eff = lock_load(load_val);

  stride_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .count (count),
    .step  (step_eff),
    .dir   (dir),
    .limit (limit),
    .start (START_V),
    .nxt   (nxt),
    .hit   (hit)
  );

  // ---- state register: count, tc, done ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= START_V;
      tc          <= 1'b0;
      done        <= 1'b0;
      state_p0    <= ST_RUN;
      sat_hold_p0 <= 1'b0;
      sat_dir_p0  <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count       <= load_eff;
        state_p0    <= ST_RUN;
        done        <= 1'b0;
        sat_hold_p0 <= 1'b0;
      end else if (en && (state_p0 == ST_RUN) && (step_eff != '0)) begin
        if (!hit) begin
          count       <= nxt;
          sat_hold_p0 <= 1'b0;
        end else begin
          unique case (mode_e)
            // Pulse only on the first blocked cycle; a reversal re-arms it.
            MODE_SAT: begin
              tc          <= !(sat_hold_p0 && (sat_dir_p0 == dir));
              sat_hold_p0 <= 1'b1;
              sat_dir_p0  <= dir;
            end
            MODE_ONESHOT: begin
              state_p0 <= ST_DONE;
              done     <= 1'b1;
              tc       <= 1'b1;
            end
            default: begin
              count       <= dir ? limit : START_V;
              tc          <= 1'b1;
              sat_hold_p0 <= 1'b0;
            end
          endcase
        end
      end
    end
  end

`ifdef STRIDE_COUNTER_PARITY_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      parity_err <= 1'b0;
    else if (load)
      parity_err <= (load_val[0] != START_V[0]);
    else if (en && (state_p0 == ST_RUN) && step[0])
      parity_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_stride_counter.sv
// Bench for stride_counter: directed scenarios plus randomized traffic against
// an arithmetic reference model.
module tb_stride_counter;

  localparam int WIDTH  = 8;
  localparam int START  = 1;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              dir;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              done;
`ifdef STRIDE_COUNTER_PARITY_LOCK_EN
  logic              parity_err;
`endif

  int tests = 0;
  int fails = 0;

  int m_count;
  int m_tc;
  int m_done;
  int m_sat_hold;
  int m_sat_dir;
  int m_perr;

  always #5 clk = ~clk;

  stride_counter #(
    .WIDTH  (WIDTH),
    .START  (START),
    .STEP_W (STEP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .dir        (dir),
    .step       (step),
    .limit      (limit),
    .mode       (mode),
    .count      (count),
    .tc         (tc),
    .done       (done)
`ifdef STRIDE_COUNTER_PARITY_LOCK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_count    = START;
    m_tc       = 0;
    m_done     = 0;
    m_sat_hold = 0;
    m_sat_dir  = 0;
    m_perr     = 0;
  endfunction

  // One clock of the counter as described in words: range check, then mode rule.
  function automatic void model_clock();
    int s, lv, lim, d, md;
    bit boundary;
    s   = int'(step);
    lv  = int'(load_val);
    lim = int'(limit);
    d   = int'(dir);
    md  = int'(mode);
    m_tc = 0;
`ifdef STRIDE_COUNTER_PARITY_LOCK_EN
    s  = s - (s % 2);
`endif
    if (load) begin
`ifdef STRIDE_COUNTER_PARITY_LOCK_EN
      m_perr = ((lv % 2) != (START % 2)) ? 1 : 0;
      lv     = lv - (lv % 2) + (START % 2);
`endif
      m_count    = lv;
      m_done     = 0;
      m_sat_hold = 0;
      return;
    end
    if (!en || m_done != 0) return;
    if (step[0]) m_perr = 1;
    if (s == 0) return;
    if (lim < START)      boundary = 1'b1;
    else if (d == 0)      boundary = (m_count + s > lim);
    else                  boundary = (m_count < START + s);
    if (!boundary) begin
      m_count    = (d != 0) ? m_count - s : m_count + s;
      m_sat_hold = 0;
      return;
    end
    if (md == 1) begin
      m_tc       = (m_sat_hold != 0 && m_sat_dir == d) ? 0 : 1;
      m_sat_hold = 1;
      m_sat_dir  = d;
    end else if (md == 2) begin
      m_done = 1;
      m_tc   = 1;
    end else begin
      m_count    = (d != 0) ? lim : START;
      m_tc       = 1;
      m_sat_hold = 0;
    end
  endfunction

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
    check("count", int'(count), m_count);
    check("tc", int'(tc), m_tc);
    check("done", int'(done), m_done);
`ifdef STRIDE_COUNTER_PARITY_LOCK_EN
    check("parity_err", int'(parity_err), m_perr);
`endif
  endtask

  // Called just after a clock edge, so the reset lands between edges.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check({tag, "_count"}, int'(count), START);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_tc"}, int'(tc), 0);
    #1 reset = 1'b0;
  endtask

  initial begin
    int pulses;
    reset = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
    dir = 1'b0; step = '0; limit = 8'd255; mode = 2'd0;
    model_reset();
    #12;
    check("rst_count", int'(count), START);
    check("rst_tc", int'(tc), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;

    // Odd sequence up to 255 then wrap.
    en = 1'b1; step = 4'd2; dir = 1'b0; limit = 8'd255; mode = 2'd0;
    for (int i = 0; i < 127; i++) tick();
    check("up_top", int'(count), 255);
    tick();
    check("up_wrap_cnt", int'(count), 1);
    check("up_wrap_tc", int'(tc), 1);
    tick();
    check("up_tc_one_cycle", int'(tc), 0);

    // Down wrap to limit.
    dir = 1'b1; limit = 8'd9; load = 1'b1; load_val = 8'd5;
    tick();
    load = 1'b0;
    tick(); tick();
    check("dn_at_start", int'(count), 1);
    tick();
    check("dn_wrap_cnt", int'(count), 9);
    check("dn_wrap_tc", int'(tc), 1);
    tick();
    check("dn_after_wrap", int'(count), 7);

    // Saturate.
    mode = 2'd1; dir = 1'b0; step = 4'd3; limit = 8'd10;
    load = 1'b1; load_val = 8'd8;
    tick();
    load = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(tc);
    end
    check("sat_hold", int'(count), 8);
    check("sat_pulses", pulses, 1);

    // One-shot from reset.
    async_reset("rst_mid");
    mode = 2'd2; dir = 1'b0; step = 4'd2; limit = 8'd7; en = 1'b1;
    tick(); tick(); tick();
    check("os_last", int'(count), 7);
    tick();
    check("os_done", int'(done), 1);
    check("os_tc", int'(tc), 1);
    tick(); tick();
    check("os_ignored", int'(count), 7);
    check("os_tc_quiet", int'(tc), 0);
    load = 1'b1; load_val = 8'd1;
    tick();
    check("os_cleared", int'(done), 0);
    load = 1'b0;
    tick();
    check("os_resume", int'(count), 3);

    // Load beats en; async reset mid-count.
    mode = 2'd0; limit = 8'd255; step = 4'd1; en = 1'b1;
    load = 1'b1; load_val = 8'h40;
    tick();
    check("load_over_en", int'(count), 'h40);
    load_val = 8'h20;
    tick();
    load = 1'b0;
    tick();
    check("pre_reset", int'(count), 'h21);
    async_reset("rst_async");

`ifdef STRIDE_COUNTER_PARITY_LOCK_EN
    load = 1'b1; load_val = 8'd4; step = 4'd3; dir = 1'b0; en = 1'b1;
    tick();
    check("par_load", int'(count), 5);
    load = 1'b0;
    tick(); tick();
    check("par_step", int'(count), 9);
    check("par_err", int'(parity_err), 1);
    load = 1'b1; load_val = 8'd5; step = 4'd2;
    tick();
    load = 1'b0;
    check("par_err_clr", int'(parity_err), 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        mode  = 2'($urandom_range(0, 3));
        limit = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 7) == 0) step = 4'($urandom);
      load     = ($urandom_range(0, 19) == 0);
      load_val = 8'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
